// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampling, optional parity, error flags and a
// power-of-two receive FIFO behind a 3-bit-address register bus.
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned FIFO_AW   = 3,
  parameter logic [7:0]  PERIOD    = 8'h1A
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wren,
  input  logic       rden,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  input  logic       rxin,
  output logic [8:0] dout,
  output logic       irq
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FullLevel = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [3:0] LastBit = 4'(DATA_BITS - 1);

  localparam logic [2:0] AddrPeriod = 3'b000;
  localparam logic [2:0] AddrThresh = 3'b010;
  localparam logic [2:0] AddrCtrl   = 3'b011;
  localparam logic [2:0] AddrData   = 3'b101;
  localparam logic [2:0] AddrLevel  = 3'b110;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // Configuration registers
  logic [7:0]       pr_q;
  logic [FIFO_AW:0] th_q;
  logic             rx_en_q, par_en_q, par_odd_q;

  logic wr_ctrl, fifo_clr, err_clr;
  assign wr_ctrl  = wren & (addr == AddrCtrl);
  assign fifo_clr = wr_ctrl & din[3];
  assign err_clr  = wr_ctrl & din[4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pr_q      <= PERIOD;
      th_q      <= '0;
      rx_en_q   <= 1'b0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
    end else if (wren) begin
      case (addr)
        AddrPeriod: pr_q <= din;
        AddrThresh: th_q <= din[FIFO_AW:0];
        AddrCtrl: begin
          rx_en_q   <= din[0];
          par_en_q  <= din[1];
          par_odd_q <= din[2];
        end
        default: ;
      endcase
    end
  end

  // Input synchroniser and falling-edge detect
  logic rx_s1_q, rx_s2_q, rx_prev_q, fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rxin;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  assign fall = rx_prev_q & ~rx_s2_q;

  // Baud tick generator; a new period is only adopted at a wrap
  state_e     state_q, state_d;
  logic [7:0] baud_cnt_q, baud_cnt_d;
  logic [7:0] pr_act_q, pr_act_d;
  logic       tick;

  assign tick = (baud_cnt_q == pr_act_q);

  always_comb begin
    baud_cnt_d = baud_cnt_q + 8'd1;
    pr_act_d   = pr_act_q;
    if (state_q == StIdle || tick) begin
      baud_cnt_d = '0;
      pr_act_d   = pr_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      baud_cnt_q <= '0;
      pr_act_q   <= PERIOD;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      pr_act_q   <= pr_act_d;
    end
  end

  // Receive FSM
  logic [3:0]           tcnt_q, tcnt_d;
  logic [3:0]           bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic                 perr_bit_q, perr_bit_d;
  logic                 push_req, frame_err, sample;

  assign sample = tick & (tcnt_q == 4'd15);

  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    bcnt_d     = bcnt_q;
    sr_d       = sr_q;
    perr_bit_d = perr_bit_q;
    push_req   = 1'b0;
    frame_err  = 1'b0;
    unique case (state_q)
      StIdle: begin
        tcnt_d     = '0;
        bcnt_d     = '0;
        perr_bit_d = 1'b0;
        if (rx_en_q && fall) state_d = StStart;
      end
      StStart: begin
        if (tick) begin
          if (tcnt_q == 4'd7) begin
            tcnt_d  = '0;
            state_d = rx_s2_q ? StIdle : StData;
          end else begin
            tcnt_d = tcnt_q + 4'd1;
          end
        end
      end
      StData: begin
        if (tick) tcnt_d = tcnt_q + 4'd1;
        if (sample) begin
          sr_d   = {rx_s2_q, sr_q[DATA_BITS-1:1]};
          bcnt_d = bcnt_q + 4'd1;
          if (bcnt_q == LastBit) state_d = par_en_q ? StParity : StStop;
        end
      end
      StParity: begin
        if (tick) tcnt_d = tcnt_q + 4'd1;
        if (sample) begin
          perr_bit_d = ((^sr_q) ^ rx_s2_q) != par_odd_q;
          state_d    = StStop;
        end
      end
      StStop: begin
        if (tick) tcnt_d = tcnt_q + 4'd1;
        if (sample) begin
          push_req  = 1'b1;
          frame_err = ~rx_s2_q;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Disabling the receiver abandons any frame in progress
    if (!rx_en_q) begin
      state_d   = StIdle;
      push_req  = 1'b0;
      frame_err = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      tcnt_q     <= '0;
      bcnt_q     <= '0;
      sr_q       <= '1;
      perr_bit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      bcnt_q     <= bcnt_d;
      sr_q       <= sr_d;
      perr_bit_q <= perr_bit_d;
    end
  end

  // Receive FIFO
  logic [DATA_BITS-1:0] mem [Depth];
  logic [FIFO_AW:0]     wptr_q, rptr_q, level;
  logic                 full, empty, pop, push;

  assign level = wptr_q - rptr_q;
  assign full  = (level == FullLevel);
  assign empty = (level == '0);
  assign pop   = rden & (addr == AddrData) & ~empty;
  assign push  = push_req & (~full | pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (fifo_clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[FIFO_AW-1:0]] <= sr_q;
  end

  // Sticky error flags; a set in the clearing cycle takes priority
  logic perr_q, ferr_q, ovr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      perr_q <= (perr_q & ~err_clr) | (push_req & perr_bit_q);
      ferr_q <= (ferr_q & ~err_clr) | frame_err;
      ovr_q  <= (ovr_q & ~err_clr) | (push_req & full & ~pop);
    end
  end

  // Read path and interrupt
  logic                 rden_q, irq_q;
  logic [2:0]           addr_q;
  logic [DATA_BITS-1:0] rdata_q;
  logic [8:0]           status;

  assign status = {3'b000, ovr_q, ferr_q, perr_q, full, ~empty, rx_en_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rden_q  <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      rden_q <= rden;
      addr_q <= addr;
      if (rden && addr == AddrData) rdata_q <= pop ? mem[rptr_q[FIFO_AW-1:0]] : '0;
      irq_q <= rx_en_q & (((level >= th_q) & (th_q != '0)) | perr_q | ferr_q | ovr_q);
    end
  end

  always_comb begin
    dout = '0;
    if (rden_q) begin
      case (addr_q)
        AddrPeriod: dout = {1'b0, pr_q};
        AddrThresh: dout = 9'(th_q);
        AddrCtrl:   dout = status;
        AddrData:   dout = 9'(rdata_q);
        AddrLevel:  dout = 9'(level);
        default:    dout = '0;
      endcase
    end
  end

  assign irq = irq_q;

endmodule
